// File: rtl/foc_sample_sequencer.sv
`timescale 1ns/1ps
// foc_sample_sequencer
// Captures one phase-current/angle sample per PWM trigger, ships it to the
// Park/Clarke transform over an AXI-stream master port, waits for the d/q
// result on an AXI-stream slave port and presents it on id_out/iq_out.
// Each transaction is bounded by a TIMEOUT_CYC watchdog. Triggers arriving
// while a transaction is in flight are dropped and counted.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   enable, trig         : trigger gate and single-cycle sample strobe
//   ia, ib, theta        : signed phase currents and rotor angle (16 b each)
//   m_axis_*             : packed sample {16'h0, ia, ib, theta} to transform
//   s_axis_*             : transform result, d in [31:16], q in [15:0]
//   id_out, iq_out       : last captured d/q currents
//   done, timeout        : one-cycle completion / abort pulses
//   busy                 : transaction in flight
//   overrun_cnt, timeout_cnt : saturating event counters
module foc_sample_sequencer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             trig,
    input  logic [15:0]      ia,
    input  logic [15:0]      ib,
    input  logic [15:0]      theta,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [15:0]      id_out,
    output logic [15:0]      iq_out,
    output logic             done,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t          state_r, state_s;
    logic [TO_W-1:0] tcnt_r, tcnt_s;
    logic            accept_s;
    logic            overrun_s;
    logic            done_s;
    logic            abort_s;
    logic [63:0]     tdata_r;
    logic            tvalid_r, s_tready_r, busy_r, done_r, timeout_r;
    logic [15:0]     id_r, iq_r;
    logic [CNT_W-1:0] ovr_cnt_r, to_cnt_r;

    // Upper result word carries no information for this block.
    logic unused_tdata_s;
    assign unused_tdata_s = ^s_axis_tdata[63:32];

    // Next-state, watchdog and event decode.
    always_comb begin
        state_s   = state_r;
        tcnt_s    = tcnt_r;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        accept_s  = (state_r == IDLE) && trig && enable;
        overrun_s = (state_r != IDLE) && trig && enable;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SEND;
                    tcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                // Watchdog has priority here: only a captured result counts
                // as completion, a handshake alone does not.
                if (tcnt_r == TO_LAST) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else if (m_axis_tready) begin
                    state_s = WAIT;
                    tcnt_s  = tcnt_r + TO_W'(1);
                end else begin
                    tcnt_s  = tcnt_r + TO_W'(1);
                end
            end
            WAIT: begin
                // A result arriving on the threshold edge still completes.
                if (s_axis_tvalid) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (tcnt_r == TO_LAST) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    tcnt_s  = tcnt_r + TO_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, sample latch, result capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tcnt_r     <= '0;
            tdata_r    <= 64'h0;
            tvalid_r   <= 1'b0;
            s_tready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            id_r       <= 16'h0;
            iq_r       <= 16'h0;
            ovr_cnt_r  <= '0;
            to_cnt_r   <= '0;
        end else begin
            state_r    <= state_s;
            tcnt_r     <= tcnt_s;
            tvalid_r   <= (state_s == SEND);
            s_tready_r <= (state_s == WAIT);
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
            timeout_r  <= abort_s;
            if (accept_s) begin
                tdata_r <= {16'h0000, ia, ib, theta};
            end
            if (done_s) begin
                id_r <= s_axis_tdata[31:16];
                iq_r <= s_axis_tdata[15:0];
            end
            if (overrun_s) begin
                ovr_cnt_r <= sat_inc(ovr_cnt_r);
            end
            if (abort_s) begin
                to_cnt_r <= sat_inc(to_cnt_r);
            end
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign s_axis_tready = s_tready_r;
    assign id_out        = id_r;
    assign iq_out        = iq_r;
    assign done          = done_r;
    assign busy          = busy_r;
    assign timeout       = timeout_r;
    assign overrun_cnt   = ovr_cnt_r;
    assign timeout_cnt   = to_cnt_r;

endmodule

// File: tb/tb_foc_sample_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for foc_sample_sequencer: a table of per-cycle vectors
// for the basic transaction, back-pressure, overrun and back-to-back cases,
// followed by hand-written sequences for watchdog, saturation and reset.
module tb_foc_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, trig;
    logic [15:0] ia, ib, theta;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [15:0] id_out, iq_out;
    logic        done, busy, timeout;
    logic [7:0]  overrun_cnt, timeout_cnt;

    int checks = 0;
    int errors = 0;

    foc_sample_sequencer #(.TIMEOUT_CYC(64), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .trig(trig),
        .ia(ia), .ib(ib), .theta(theta),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .id_out(id_out), .iq_out(iq_out), .done(done), .busy(busy),
        .timeout(timeout), .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, trg;
        logic [15:0] ia, ib, th;
        logic        mrdy, svld;
        logic [63:0] sdata;
        logic        e_mvld, e_srdy, e_busy, e_done, e_to;
        logic [63:0] e_mdata;
        logic [15:0] e_id, e_iq;
        logic [7:0]  e_ovr, e_tocnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] D1 = 64'h0000_FC28_FDA8_0064;
    localparam logic [63:0] D2 = 64'h0000_0100_0200_0300;

    initial begin
        int n;
        int to_seen;

        tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,64'h0,
                    1'b0,1'b0,1'b0,1'b0,1'b0,64'h0,16'h0000,16'h0000,8'd0,8'd0};
        // trigger: latch sample, SEND next cycle
        tbl[1]  = '{1'b0,1'b1,1'b1,16'hFC28,16'hFDA8,16'h0064,1'b1,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D1,16'h0000,16'h0000,8'd0,8'd0};
        // inputs change after latch; handshake -> WAIT
        tbl[2]  = '{1'b0,1'b1,1'b0,16'h1111,16'h2222,16'h3333,1'b1,1'b0,64'h0,
                    1'b0,1'b1,1'b1,1'b0,1'b0,D1,16'h0000,16'h0000,8'd0,8'd0};
        // result presented in WAIT -> done
        tbl[3]  = '{1'b0,1'b1,1'b0,16'h1111,16'h2222,16'h3333,1'b1,1'b1,64'h0000_0000_0123_FF45,
                    1'b0,1'b0,1'b0,1'b1,1'b0,D1,16'h0123,16'hFF45,8'd0,8'd0};
        // trig in the done cycle is accepted
        tbl[4]  = '{1'b0,1'b1,1'b1,16'h0100,16'h0200,16'h0300,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd0,8'd0};
        // tready low: three overrun triggers, one disabled trigger, one idle
        tbl[5]  = '{1'b0,1'b1,1'b1,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd1,8'd0};
        tbl[6]  = '{1'b0,1'b1,1'b1,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd2,8'd0};
        tbl[7]  = '{1'b0,1'b1,1'b1,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd3,8'd0};
        tbl[8]  = '{1'b0,1'b0,1'b1,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd3,8'd0};
        tbl[9]  = '{1'b0,1'b1,1'b0,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b0,64'h0,
                    1'b1,1'b0,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd3,8'd0};
        // 6th cycle: transfer
        tbl[10] = '{1'b0,1'b1,1'b0,16'hAAAA,16'hBBBB,16'hCCCC,1'b1,1'b0,64'h0,
                    1'b0,1'b1,1'b1,1'b0,1'b0,D2,16'h0123,16'hFF45,8'd3,8'd0};
        tbl[11] = '{1'b0,1'b1,1'b0,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b1,64'hDEAD_BEEF_7FFF_8000,
                    1'b0,1'b0,1'b0,1'b1,1'b0,D2,16'h7FFF,16'h8000,8'd3,8'd0};
        // stray result while idle is ignored
        tbl[12] = '{1'b0,1'b1,1'b0,16'hAAAA,16'hBBBB,16'hCCCC,1'b0,1'b1,64'h0000_0000_5555_AAAA,
                    1'b0,1'b0,1'b0,1'b0,1'b0,D2,16'h7FFF,16'h8000,8'd3,8'd0};

        reset = 1'b1; enable = 1'b0; trig = 1'b0;
        ia = 16'h0; ib = 16'h0; theta = 16'h0;
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 64'h0;
        tick();

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; trig = tbl[i].trg;
            ia = tbl[i].ia; ib = tbl[i].ib; theta = tbl[i].th;
            m_axis_tready = tbl[i].mrdy; s_axis_tvalid = tbl[i].svld;
            s_axis_tdata = tbl[i].sdata;
            tick();
            chk("m_tvalid", i, 64'(m_axis_tvalid), 64'(tbl[i].e_mvld));
            chk("s_tready", i, 64'(s_axis_tready), 64'(tbl[i].e_srdy));
            chk("busy",     i, 64'(busy),          64'(tbl[i].e_busy));
            chk("done",     i, 64'(done),          64'(tbl[i].e_done));
            chk("timeout",  i, 64'(timeout),       64'(tbl[i].e_to));
            chk("m_tdata",  i, m_axis_tdata,       tbl[i].e_mdata);
            chk("id_out",   i, 64'(id_out),        64'(tbl[i].e_id));
            chk("iq_out",   i, 64'(iq_out),        64'(tbl[i].e_iq));
            chk("ovr_cnt",  i, 64'(overrun_cnt),   64'(tbl[i].e_ovr));
            chk("to_cnt",   i, 64'(timeout_cnt),   64'(tbl[i].e_tocnt));
        end

        // Watchdog: no result ever, timeout 64 cycles after SEND entry.
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; enable = 1'b1; trig = 1'b1;
        tick();
        trig = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout && n < 200);
        chk("to_latency", 0, 64'(n), 64'd64);
        chk("to_cnt",     100, 64'(timeout_cnt), 64'd1);
        chk("to_busy",    0, 64'(busy), 64'd0);
        chk("to_id",      0, 64'(id_out), 64'h7FFF);
        chk("to_iq",      0, 64'(iq_out), 64'h8000);
        chk("to_mvld",    0, 64'(m_axis_tvalid), 64'd0);
        chk("to_srdy",    0, 64'(s_axis_tready), 64'd0);
        tick();
        chk("to_pulse",   0, 64'(timeout), 64'd0);

        // Result on the threshold edge: completion wins.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        to_seen = 0;
        for (int k = 0; k < 63; k++) begin
            tick();
            if (timeout) to_seen++;
        end
        chk("race_early_to", 0, 64'(to_seen), 64'd0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h0000_0000_1234_5678;
        tick();
        s_axis_tvalid = 1'b0;
        chk("race_done",  0, 64'(done), 64'd1);
        chk("race_to",    0, 64'(timeout), 64'd0);
        chk("race_id",    0, 64'(id_out), 64'h1234);
        chk("race_iq",    0, 64'(iq_out), 64'h5678);
        chk("race_tocnt", 0, 64'(timeout_cnt), 64'd1);

        // Overrun saturation: trig held for 300 cycles.
        m_axis_tready = 1'b0; trig = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        trig = 1'b0;
        chk("ovr_sat", 0, 64'(overrun_cnt), 64'd255);

        // Reset in WAIT, with a trig during reset, then a late result.
        reset = 1'b1;
        tick();
        chk("rst_ovr", 0, 64'(overrun_cnt), 64'd0);
        chk("rst_to",  0, 64'(timeout_cnt), 64'd0);
        reset = 1'b0; m_axis_tready = 1'b1; trig = 1'b1;
        ia = 16'h0ABC; ib = 16'h0DEF; theta = 16'h0123;
        tick();
        trig = 1'b0;
        tick();
        chk("wait_srdy", 0, 64'(s_axis_tready), 64'd1);
        reset = 1'b1; trig = 1'b1;
        tick();
        chk("rst_mvld",  1, 64'(m_axis_tvalid), 64'd0);
        chk("rst_srdy",  1, 64'(s_axis_tready), 64'd0);
        chk("rst_busy",  1, 64'(busy), 64'd0);
        chk("rst_done",  1, 64'(done), 64'd0);
        chk("rst_tout",  1, 64'(timeout), 64'd0);
        chk("rst_mdata", 1, m_axis_tdata, 64'h0);
        chk("rst_id",    1, 64'(id_out), 64'h0);
        chk("rst_iq",    1, 64'(iq_out), 64'h0);
        reset = 1'b0; trig = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h0000_0000_7777_6666;
        tick();
        chk("late_done", 0, 64'(done), 64'd0);
        chk("late_srdy", 0, 64'(s_axis_tready), 64'd0);
        chk("late_busy", 0, 64'(busy), 64'd0);
        chk("late_id",   0, 64'(id_out), 64'h0);
        s_axis_tvalid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/foc_sample_sequencer.md
FOC_SAMPLE_SEQUENCER -- requirements
Module: foc_sample_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYC, default 64: maximum cycles from SEND entry to result acceptance.
REQ-003 Parameter CNT_W, default 8: width of the error counters.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  1 = triggers accepted; 0 = triggers ignored; an in-flight transaction still completes.
REQ-007 trig  input  1  single-cycle PWM-period sample strobe.
REQ-008 ia, ib  input  16 each  signed phase currents (two's complement).
REQ-009 theta  input  16  rotor electrical angle.
REQ-010 m_axis_tdata  output  64  packed sample to the Park/Clarke transform.
REQ-011 m_axis_tvalid  output  1 / m_axis_tready  input  1  AXI-stream handshake toward the transform.
REQ-012 s_axis_tdata  input  64  transform result.
REQ-013 s_axis_tvalid  input  1 / s_axis_tready  output  1  AXI-stream handshake from the transform.
REQ-014 id_out, iq_out  output  16 each  last captured d/q currents.
REQ-015 done  output  1  one-cycle pulse on result capture.
REQ-016 busy  output  1  high whenever state != IDLE.
REQ-017 timeout  output  1  one-cycle pulse on transaction abort.
REQ-018 overrun_cnt, timeout_cnt  output  CNT_W each  saturating event counters.

Function
REQ-019 States SHALL be IDLE, SEND and WAIT; IDLE is the reset state.
REQ-020 IDLE with trig=1 and enable=1: latch ia/ib/theta at that edge and enter SEND on the next cycle.
REQ-021 m_axis_tdata SHALL be {16'h0000, ia, ib, theta}, with ia in [47:32], ib in [31:16] and theta in [15:0], from the latched values, and SHALL be stable while m_axis_tvalid=1.
REQ-022 SEND: m_axis_tvalid=1; on m_axis_tvalid & m_axis_tready go to WAIT at that edge, with m_axis_tvalid=0 from the next cycle.
REQ-023 WAIT: s_axis_tready=1; s_axis_tready SHALL be 0 in every other state, and s_axis_tvalid outside WAIT is ignored.
REQ-024 WAIT with s_axis_tvalid=1: capture id_out=s_axis_tdata[31:16] and iq_out=s_axis_tdata[15:0], pulse done for one cycle, and return to IDLE at that edge.
REQ-025 Minimum latency with an always-ready transform: trig at edge N, SEND at cycle N+1, WAIT at N+2; a result presented at N+2 gives done=1 in cycle N+3.
REQ-026 The timeout counter SHALL clear on SEND entry and increment each cycle in SEND or WAIT; reaching TIMEOUT_CYC-1 without completion SHALL cause, at the next edge:
- return to IDLE;
- timeout pulsed for one cycle;
- timeout_cnt incremented;
- m_axis_tvalid and s_axis_tready dropped;
- id_out and iq_out unchanged.
REQ-027 trig=1 with enable=1 while busy=1 SHALL be dropped and SHALL increment overrun_cnt; with enable=0 it SHALL have no effect.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-029 trig in the cycle where done or timeout is high SHALL be accepted, because the state is IDLE then.
REQ-030 Completion and the timeout threshold on the same edge: completion wins; done pulses and timeout stays 0.
REQ-031 ia, ib and theta changing after the latch edge SHALL NOT alter m_axis_tdata.

Reset
REQ-032 reset=1 at any edge, including mid-transaction, SHALL force:
- state=IDLE;
- m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata=0;
- id_out=0, iq_out=0;
- done=0, busy=0, timeout=0;
- overrun_cnt=0, timeout_cnt=0;
- the in-flight sample discarded.
REQ-033 No trig is accepted in a cycle where reset=1.

Verification
REQ-034 ia=16'hFC28, ib=16'hFDA8, theta=16'h0064, trig, tready=1, result 64'h0000_0000_0123_FF45 returned in WAIT -> m_axis_tdata=64'h0000_FC28_FDA8_0064, id_out=16'h0123, iq_out=16'hFF45, done high for exactly one cycle, N+3 latency.
REQ-035 m_axis_tready held low 5 cycles -> m_axis_tvalid and tdata stable for 5 cycles, transfer on the 6th cycle, normal completion.
REQ-036 s_axis_tvalid never asserted, TIMEOUT_CYC=64 -> timeout pulses 64 cycles after SEND entry, timeout_cnt=1, busy=0, id_out/iq_out unchanged.
REQ-037 Three triggers while busy, then one with enable=0 -> overrun_cnt=3; 300 triggers while busy -> overrun_cnt=255.
REQ-038 reset asserted in WAIT -> next cycle all outputs at reset values; a late s_axis_tvalid is ignored (s_axis_tready=0, no done).
REQ-039 trig in the done cycle -> second transaction starts with SEND the next cycle, overrun_cnt unchanged.
